if_id_skid_stage: RTL
=====================

Name: if_id_skid_stage

Overview:
- Parametrised IF/ID pipeline stage carrying PC+1 and the fetched instruction from fetch to decode.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is driven from a flop and never from out_ready combinationally.
- Adds a global hold (writeEnable), a flush that inserts a bubble, and a saturating back-pressure counter.
- Sits between the PC/instruction-memory logic and the decode/register-file stage.

Parameters:
- PC_W, 32, width of PC+1 field
- INSTR_W, 32, width of instruction field
- NOP_INSTR, 32'h0000_0000, instruction value presented on a bubble/reset (INSTR_W bits)
- STALL_CNT_W, 16, width of the back-pressure counter

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- writeEnable  in  1  global enable; 0 freezes all state (hazard-unit stall)
- Flush  in  1  synchronous squash of all held entries (branch/jump taken)
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  stage can accept; registered
- PCplusOne  in  PC_W  PC+1 from fetch
- Instr  in  INSTR_W  instruction from fetch
- out_valid  out  1  decode-side entry valid
- out_ready  in  1  decode accepts
- PCplusOneOut  out  PC_W  registered PC+1
- InstrOut  out  INSTR_W  registered instruction
- StallCount  out  STALL_CNT_W  cycles with out_valid=1, out_ready=0, writeEnable=1; saturating

Behaviour:
- Sync reset at Reset=1, which overrides everything:
  - main_v=0, skid_v=0, in_ready=1, out_valid=0
  - PCplusOneOut=0, InstrOut=NOP_INSTR, StallCount=0
- Transfers: accept = in_valid & in_ready & writeEnable; deliver = out_valid & out_ready & writeEnable.
- Outputs always come from the main register. Skid data is never visible at the outputs.
- Three states, encoded by {skid_v, main_v}:
  - EMPTY (00): accept -> main loads input -> BUSY.
  - BUSY (01):
    - accept & deliver -> main reloads, stays BUSY.
    - accept & !deliver -> skid loads input -> FULL, in_ready=0 next cycle.
    - !accept & deliver -> EMPTY.
  - FULL (11): in_ready=0, so no accept. deliver -> main takes skid, skid_v=0 -> BUSY, in_ready=1 next cycle.
- Latency: 1 cycle from accept to out_valid when EMPTY. Sustained throughput is 1 entry/cycle when out_ready stays high. Order is strictly FIFO.
- writeEnable=0: no state, data or counter change. in_ready and out_valid hold their values, but no transfer occurs regardless of the handshake signals.
- Flush=1 (with Reset=0):
  - Next cycle: main_v=0, skid_v=0, in_ready=1, PCplusOneOut=0, InstrOut=NOP_INSTR.
  - Same-cycle input is discarded, not accepted.
  - Flush wins over writeEnable=0 and over any simultaneous accept/deliver.
  - A deliver coincident with Flush still counts as consumed by decode (decode sampled it that cycle).
- While out_valid=0: PCplusOneOut/InstrOut hold their last loaded values. After reset or flush those are 0/NOP.
- StallCount: +1 per cycle when out_valid & !out_ready & writeEnable. Holds at 2^STALL_CNT_W-1 (no wrap). Cleared by Reset only, not by Flush.
- No combinational path from out_ready or in_valid to in_ready.

Decomposition:
- Shared package holds the NOP_INSTR default constant and the state encoding localparams (S_EMPTY, S_BUSY, S_FULL). PC_W and INSTR_W defaults are shared with the other pipeline-register stages.
- One natural sub-module: pipe_entry_reg, an enable + sync-clear register of width PC_W+INSTR_W+1 with a clear value {0, NOP_INSTR, 0}. It is instantiated twice (main and skid).
- Counter and state logic stay in the top module.

Test Plan:
- Reset, then in_valid=1, PCplusOne=32'h5, Instr=32'hAB, out_ready=1, writeEnable=1 -> next cycle out_valid=1, PCplusOneOut=5, InstrOut=AB. Holding these inputs gives one entry per cycle, no bubbles.
- Stream 1,2,3 with out_ready=0 from cycle 2 -> state goes FULL, in_ready=0 after entry 2. Releasing out_ready delivers 1,2,3 in order with none lost or duplicated. StallCount equals the number of blocked cycles.
- FULL state plus Flush=1 and in_valid=1 (PC=9) -> next cycle out_valid=0, in_ready=1, InstrOut=NOP_INSTR, PCplusOneOut=0. Entry 9 is never delivered.
- writeEnable=0 for 3 cycles with in_valid=1 and out_ready toggling -> outputs, state and StallCount unchanged. On re-enable, operation resumes from the same entry.
- Flush=1 together with writeEnable=0 -> flush still takes effect; Reset=1 together with Flush=1 -> reset values, StallCount=0.
- STALL_CNT_W=3 with out_ready=0 for 10 cycles while valid -> StallCount saturates at 7 and holds. A subsequent Flush leaves it at 7.

Source files
------------

// File: rtl/if_id_skid_stage_pkg.sv
// Shared definitions for the IF/ID pipeline register stage: default field
// widths, the bubble instruction and the {skid_v, main_v} state encoding.
package if_id_skid_stage_pkg;

    // Field widths shared with the other pipeline-register stages.
    localparam int unsigned PC_W_DEFAULT    = 32;
    localparam int unsigned INSTR_W_DEFAULT = 32;

    // Instruction presented while the stage holds a bubble or after reset.
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    // Occupancy encoding, {skid_v, main_v}.
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_BUSY  = 2'b01;
    localparam logic [1:0] S_FULL  = 2'b11;

    typedef enum logic [1:0] {
        StEmpty = S_EMPTY,
        StBusy  = S_BUSY,
        StFull  = S_FULL
    } state_e;

endpackage

// File: rtl/if_id_skid_stage_pipe_entry_reg.sv
// One pipeline entry {pc, instr, valid} with load enable and synchronous clear.
// Clear value is {0, NOP_INSTR, 0} so a cleared entry reads as a bubble.
module pipe_entry_reg
    import if_id_skid_stage_pkg::*;
#(
    parameter int unsigned         PC_W      = PC_W_DEFAULT,
    parameter int unsigned         INSTR_W   = INSTR_W_DEFAULT,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(NOP_INSTR_DEFAULT)
) (
    input  logic                    clk_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic [PC_W+INSTR_W:0]   d_i,
    output logic [PC_W+INSTR_W:0]   q_o
);

    localparam logic [PC_W+INSTR_W:0] ClearVal = {{PC_W{1'b0}}, NOP_INSTR, 1'b0};

    logic [PC_W+INSTR_W:0] entry_q;

    // Entry register: clear has priority over load.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            entry_q <= ClearVal;
        end else if (en_i) begin
            entry_q <= d_i;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline stage with a 2-entry skid buffer. Outputs always come from
// the main entry; the skid entry only absorbs the one extra beat that fetch
// can push in the cycle after decode stalls, which keeps in_ready registered.
module if_id_skid_stage
    import if_id_skid_stage_pkg::*;
#(
    parameter int unsigned         PC_W        = PC_W_DEFAULT,
    parameter int unsigned         INSTR_W     = INSTR_W_DEFAULT,
    parameter logic [INSTR_W-1:0]  NOP_INSTR   = INSTR_W'(NOP_INSTR_DEFAULT),
    parameter int unsigned         STALL_CNT_W = 16
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    writeEnable,
    input  logic                    Flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         PCplusOne,
    input  logic [INSTR_W-1:0]      Instr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W-1:0]         PCplusOneOut,
    output logic [INSTR_W-1:0]      InstrOut,
    output logic [STALL_CNT_W-1:0]  StallCount
);

    localparam int unsigned EntryW = PC_W + INSTR_W + 1;

    logic [EntryW-1:0]      main_q, main_d, skid_q, skid_d, in_entry;
    logic                   main_en, skid_en, entry_clr;
    logic                   main_v, skid_v, skid_v_d;
    logic                   accept, deliver;
    logic                   in_ready_q, in_ready_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    state_e                 state;

    assign main_v    = main_q[0];
    assign skid_v    = skid_q[0];
    assign state     = state_e'({skid_v, main_v});
    assign entry_clr = Reset | Flush;
    assign in_entry  = {PCplusOne, Instr, 1'b1};

    // A flushed cycle never accepts; a deliver during flush needs no state change.
    assign accept  = in_valid & in_ready_q & writeEnable & ~Flush;
    assign deliver = main_v & out_ready & writeEnable;

    pipe_entry_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_main (
        .clk_i (Clk),
        .clr_i (entry_clr),
        .en_i  (main_en),
        .d_i   (main_d),
        .q_o   (main_q)
    );

    pipe_entry_reg #(
        .PC_W      (PC_W),
        .INSTR_W   (INSTR_W),
        .NOP_INSTR (NOP_INSTR)
    ) u_skid (
        .clk_i (Clk),
        .clr_i (entry_clr),
        .en_i  (skid_en),
        .d_i   (skid_d),
        .q_o   (skid_q)
    );

    // Occupancy next-state: decide which entry loads what this cycle.
    always_comb begin
        main_en  = 1'b0;
        main_d   = main_q;
        skid_en  = 1'b0;
        skid_d   = skid_q;
        skid_v_d = skid_v;
        unique case (state)
            StEmpty: begin
                if (accept) begin
                    main_en = 1'b1;
                    main_d  = in_entry;
                end
            end
            StBusy: begin
                if (accept && deliver) begin
                    main_en = 1'b1;
                    main_d  = in_entry;
                end else if (accept) begin
                    skid_en  = 1'b1;
                    skid_d   = in_entry;
                    skid_v_d = 1'b1;
                end else if (deliver) begin
                    // Drop valid but keep the last payload visible.
                    main_en = 1'b1;
                    main_d  = {main_q[EntryW-1:1], 1'b0};
                end
            end
            StFull: begin
                if (deliver) begin
                    main_en  = 1'b1;
                    main_d   = skid_q;
                    skid_en  = 1'b1;
                    skid_d   = {skid_q[EntryW-1:1], 1'b0};
                    skid_v_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Ready next-state: open whenever the skid entry will be free.
    always_comb begin
        in_ready_d = in_ready_q;
        if (Flush) begin
            in_ready_d = 1'b1;
        end else if (writeEnable) begin
            in_ready_d = ~skid_v_d;
        end
    end

    // Ready register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_ready_q <= 1'b1;
        end else begin
            in_ready_q <= in_ready_d;
        end
    end

    // Back-pressure counter next-state: saturating, untouched by flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (writeEnable && main_v && !out_ready && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
        end
    end

    // Back-pressure counter register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = main_v;
    assign PCplusOneOut = main_q[EntryW-1 -: PC_W];
    assign InstrOut     = main_q[INSTR_W:1];
    assign StallCount   = stall_cnt_q;

endmodule
